// File: rtl/xcr_trap_seq.sv
// rtl/xcr_trap_seq.sv - interrupt trap entry/return sequencer with EPC/TCNT control registers
//
// Purpose: detects a pending interrupt, waits for an instruction boundary,
// saves the return PC (EPC), redirects fetch to the vector, and on eret
// redirects back to EPC. Software can read/write EPC and read/clear TCNT.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   INT, IVEC_ADDR      interrupt request level and its vector address
//   pc_cur              address of the next instruction to execute
//   instr_boundary      CPU may be redirected this cycle
//   eret                return-from-interrupt retired (pulse)
//   stall_req           hold fetch
//   pc_load, pc_target  PC redirect pulse and address (target is 0 when idle)
//   int_ack             pulse on trap entry
//   in_handler          handler active, INT masked
//   cr_din/cr_dout/cr_adr/cr_we/cr_cs  control-register port

module xcr_trap_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic [23:0] IVEC_ADDR,
    input  logic [23:0] pc_cur,
    input  logic        instr_boundary,
    input  logic        eret,
    output logic        stall_req,
    output logic        pc_load,
    output logic [23:0] pc_target,
    output logic        int_ack,
    output logic        in_handler,
    input  logic [7:0]  cr_din,
    output logic [7:0]  cr_dout,
    input  logic [2:0]  cr_adr,
    input  logic        cr_we,
    input  logic        cr_cs
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_JUMP    = 3'd2,
        S_HANDLER = 3'd3,
        S_RET     = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [23:0] r_epc;
    logic [23:0] r_vec;
    logic [7:0]  r_tcnt;
    logic        w_capture;
    logic        w_cr_wr;
    logic [2:0]  w_state_code;

    assign w_cr_wr      = cr_cs & cr_we;
    assign w_state_code = r_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outputs are a pure decode of the current state, so an asynchronous
    // reset drops every redirect/stall output in the same instant.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        stall_req   = 1'b0;
        pc_load     = 1'b0;
        pc_target   = 24'h000000;
        int_ack     = 1'b0;
        in_handler  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (INT) begin
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                stall_req = 1'b1;
                if (!INT) begin
                    // request withdrawn before a boundary: nothing captured
                    w_state_nxt = S_IDLE;
                end else if (instr_boundary) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_JUMP;
                end
            end
            S_JUMP: begin
                stall_req   = 1'b1;
                pc_load     = 1'b1;
                pc_target   = r_vec;
                int_ack     = 1'b1;
                in_handler  = 1'b1;
                w_state_nxt = S_HANDLER;
            end
            S_HANDLER: begin
                in_handler = 1'b1;
                if (eret) begin
                    w_state_nxt = S_RET;
                end
            end
            S_RET: begin
                stall_req   = 1'b1;
                pc_load     = 1'b1;
                pc_target   = r_epc;
                in_handler  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Hardware capture takes priority over a same-cycle software byte write
    // so the saved return address is never a mix of old and new bytes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_epc <= 24'h000000;
        end else if (w_capture) begin
            r_epc <= pc_cur;
        end else if (w_cr_wr) begin
            case (cr_adr)
                3'd0:    r_epc[7:0]   <= cr_din;
                3'd1:    r_epc[15:8]  <= cr_din;
                3'd2:    r_epc[23:16] <= cr_din;
                default: r_epc        <= r_epc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vec <= 24'h000000;
        end else if (w_capture) begin
            r_vec <= IVEC_ADDR;
        end
    end

    // A software clear beats the entry increment in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tcnt <= 8'h00;
        end else if (w_cr_wr && (cr_adr == 3'd4)) begin
            r_tcnt <= 8'h00;
        end else if ((r_state == S_JUMP) && (r_tcnt != 8'hFF)) begin
            r_tcnt <= r_tcnt + 8'd1;
        end
    end

    // Read decode ignores cr_cs.
    always_comb begin
        cr_dout = 8'h00;
        case (cr_adr)
            3'd0:    cr_dout = r_epc[7:0];
            3'd1:    cr_dout = r_epc[15:8];
            3'd2:    cr_dout = r_epc[23:16];
            3'd3:    cr_dout = {in_handler, 4'b0000, w_state_code};
            3'd4:    cr_dout = r_tcnt;
            default: cr_dout = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_xcr_trap_seq.sv
// tb/tb_xcr_trap_seq.sv - scoreboard bench for xcr_trap_seq with directed and random stimulus

module tb_xcr_trap_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        INT = 1'b0;
    logic [23:0] IVEC_ADDR = 24'h0;
    logic [23:0] pc_cur = 24'h0;
    logic        instr_boundary = 1'b0;
    logic        eret = 1'b0;
    logic        stall_req;
    logic        pc_load;
    logic [23:0] pc_target;
    logic        int_ack;
    logic        in_handler;
    logic [7:0]  cr_din = 8'h0;
    logic [7:0]  cr_dout;
    logic [2:0]  cr_adr = 3'd0;
    logic        cr_we = 1'b0;
    logic        cr_cs = 1'b0;

    xcr_trap_seq dut (
        .clk(clk), .rst(rst), .INT(INT), .IVEC_ADDR(IVEC_ADDR), .pc_cur(pc_cur),
        .instr_boundary(instr_boundary), .eret(eret), .stall_req(stall_req),
        .pc_load(pc_load), .pc_target(pc_target), .int_ack(int_ack),
        .in_handler(in_handler), .cr_din(cr_din), .cr_dout(cr_dout),
        .cr_adr(cr_adr), .cr_we(cr_we), .cr_cs(cr_cs)
    );

    always #5 clk = ~clk;

    localparam int M_IDLE = 0, M_ARM = 1, M_JUMP = 2, M_HANDLER = 3, M_RET = 4;

    typedef struct packed {
        logic [3:0]  flags;   // stall, load, ack, in_handler
        logic [23:0] tgt;
        logic [7:0]  dout;
    } st_t;

    typedef struct packed {
        logic [23:0] tgt;
        logic        entry;
    } ev_t;

    st_t  st_q[$];
    ev_t  ev_q[$];

    int          total = 0;
    int          bad = 0;
    int          acks = 0;
    bit          started = 1'b0;

    int          m_mode = M_IDLE;
    logic [23:0] m_epc = 24'h0;
    logic [23:0] m_vec = 24'h0;
    int          m_tcnt = 0;

    logic [23:0] cur_vec = 24'h0;
    logic [23:0] cur_pc = 24'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] m_read(input logic [2:0] a);
        logic inh;
        logic [2:0] code;
        inh  = (m_mode == M_JUMP) || (m_mode == M_HANDLER) || (m_mode == M_RET);
        code = 3'(m_mode);
        case (a)
            3'd0:    return m_epc[7:0];
            3'd1:    return m_epc[15:8];
            3'd2:    return m_epc[23:16];
            3'd3:    return {inh, 4'b0000, code};
            3'd4:    return 8'(m_tcnt);
            default: return 8'h00;
        endcase
    endfunction

    // Drive one cycle of inputs at the falling edge, advance the reference
    // model across the coming rising edge, and queue what the DUT should show.
    task automatic cyc(input bit r, input bit i, input logic [23:0] v, input logic [23:0] p,
                       input bit b, input bit e, input bit cs, input bit we,
                       input logic [2:0] a, input logic [7:0] d);
        bit  prev_rst;
        int  nm;
        st_t s;
        @(negedge clk);
        prev_rst       = rst;
        rst            = r;
        INT            = i;
        IVEC_ADDR      = v;
        pc_cur         = p;
        instr_boundary = b;
        eret           = e;
        cr_cs          = cs;
        cr_we          = we;
        cr_adr         = a;
        cr_din         = d;
        started        = 1'b1;
        if (!r && prev_rst) begin
            #1;
            chk("rst_async_flags", 32'({stall_req, pc_load, int_ack, in_handler}), 32'h0);
            chk("rst_async_target", 32'(pc_target), 32'h0);
        end
        if (!r) begin
            m_mode = M_IDLE;
            m_epc  = 24'h0;
            m_vec  = 24'h0;
            m_tcnt = 0;
        end else begin
            nm = m_mode;
            if (cs && we && (a < 3'd3)) m_epc[int'(a)*8 +: 8] = d;
            if (m_mode == M_JUMP && m_tcnt < 255) m_tcnt++;
            if (cs && we && (a == 3'd4)) m_tcnt = 0;
            case (m_mode)
                M_IDLE:    if (i) nm = M_ARM;
                M_ARM:     if (!i) nm = M_IDLE;
                           else if (b) begin m_epc = p; m_vec = v; nm = M_JUMP; end
                M_JUMP:    nm = M_HANDLER;
                M_HANDLER: if (e) nm = M_RET;
                default:   nm = M_IDLE;
            endcase
            m_mode = nm;
            if (m_mode == M_JUMP) ev_q.push_back('{tgt: m_vec, entry: 1'b1});
            if (m_mode == M_RET)  ev_q.push_back('{tgt: m_epc, entry: 1'b0});
        end
        s.flags = {(m_mode == M_ARM) || (m_mode == M_JUMP) || (m_mode == M_RET),
                   (m_mode == M_JUMP) || (m_mode == M_RET),
                   (m_mode == M_JUMP),
                   (m_mode == M_JUMP) || (m_mode == M_HANDLER) || (m_mode == M_RET)};
        s.tgt   = (m_mode == M_JUMP) ? m_vec : (m_mode == M_RET) ? m_epc : 24'h0;
        s.dout  = m_read(a);
        st_q.push_back(s);
    endtask

    task automatic step(input bit i, input bit b, input bit e);
        cyc(1'b1, i, cur_vec, cur_pc, b, e, 1'b0, 1'b0, 3'd3, 8'h00);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d, input bit i);
        cyc(1'b1, i, cur_vec, cur_pc, 1'b0, 1'b0, 1'b1, 1'b1, a, d);
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input bit i, input logic [7:0] exp);
        cyc(1'b1, i, cur_vec, cur_pc, 1'b0, 1'b0, 1'b0, 1'b0, a, 8'h00);
        @(posedge clk);
        #2;
        chk(name, 32'(cr_dout), 32'(exp));
    endtask

    task automatic redirect_chk(input string name, input logic [23:0] exp);
        @(posedge clk);
        #2;
        chk({name, "_load"}, 32'(pc_load), 32'h1);
        chk({name, "_target"}, 32'(pc_target), 32'(exp));
    endtask

    // Monitor: one status entry per cycle, one redirect event per pc_load.
    initial begin
        st_t s;
        ev_t ev;
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                if (st_q.size() == 0) begin
                    chk("status_queue_empty", 32'h1, 32'h0);
                end else begin
                    s = st_q.pop_front();
                    chk("flags", 32'({stall_req, pc_load, int_ack, in_handler}), 32'(s.flags));
                    chk("pc_target", 32'(pc_target), 32'(s.tgt));
                    chk("cr_dout", 32'(cr_dout), 32'(s.dout));
                end
                if (pc_load) begin
                    if (ev_q.size() == 0) begin
                        chk("redirect_unexpected", 32'h1, 32'h0);
                    end else begin
                        ev = ev_q.pop_front();
                        chk("redirect_addr", 32'(pc_target), 32'(ev.tgt));
                        chk("redirect_kind", 32'(int_ack), 32'(ev.entry));
                    end
                end
                if (int_ack) acks++;
            end
        end
    end

    initial begin
        int          ack0;
        logic [31:0] rv;
        logic [31:0] rp;
        logic [31:0] rd;

        cyc(1'b0, 0, 24'h0, 24'h0, 0, 0, 0, 0, 3'd3, 8'h00);
        cyc(1'b0, 0, 24'h0, 24'h0, 0, 0, 0, 0, 3'd4, 8'h00);
        rd_chk("reset_tstat", 3'd3, 1'b0, 8'h00);

        // basic entry: two edges from INT to redirect
        cur_vec = 24'h001040;
        cur_pc  = 24'h000200;
        step(1, 1, 0);
        step(1, 1, 0);
        redirect_chk("basic", 24'h001040);
        step(0, 0, 0);
        rd_chk("basic_epc0", 3'd0, 1'b0, 8'h00);
        rd_chk("basic_epc1", 3'd1, 1'b0, 8'h02);
        rd_chk("basic_epc2", 3'd2, 1'b0, 8'h00);
        rd_chk("basic_tcnt", 3'd4, 1'b0, 8'h01);

        // return through software-written EPC
        wr(3'd0, 8'h04, 1'b0);
        wr(3'd1, 8'h02, 1'b0);
        wr(3'd2, 8'h00, 1'b0);
        step(0, 0, 1);
        redirect_chk("return", 24'h000204);
        step(0, 0, 0);
        rd_chk("after_ret_tstat", 3'd3, 1'b0, 8'h00);

        // masking while in handler, then re-entry straight after RET
        wr(3'd4, 8'h5A, 1'b0);
        step(1, 1, 0);
        step(1, 1, 0);
        step(1, 1, 0);
        step(1, 1, 0);
        step(1, 1, 0);
        rd_chk("masked_tstat", 3'd3, 1'b1, 8'h83);
        step(1, 1, 1);
        step(1, 1, 0);
        step(1, 1, 0);
        step(1, 1, 0);
        step(0, 0, 0);
        rd_chk("reentry_tcnt", 3'd4, 1'b0, 8'h02);
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        rd_chk("eret_idle_tstat", 3'd3, 1'b0, 8'h00);

        // boundary delayed three cycles in ARM
        ack0 = acks;
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        step(0, 0, 0);
        rd_chk("delayed_handler", 3'd3, 1'b0, 8'h83);
        chk("delayed_one_ack", 32'(acks - ack0), 32'h1);
        step(0, 0, 1);
        step(0, 0, 0);

        // spurious request
        step(1, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        rd_chk("spurious_tcnt", 3'd4, 1'b0, 8'h03);

        // EPC write racing the capture, TCNT clear racing the increment
        cur_pc = 24'hABCDEF;
        step(1, 0, 0);
        cyc(1'b1, 1, cur_vec, cur_pc, 1, 0, 1, 1, 3'd1, 8'h55);
        cyc(1'b1, 0, cur_vec, cur_pc, 0, 0, 1, 1, 3'd4, 8'h00);
        rd_chk("capture_wins_epc1", 3'd1, 1'b0, 8'hCD);
        rd_chk("clear_wins_tcnt", 3'd4, 1'b0, 8'h00);
        step(0, 0, 1);
        step(0, 0, 0);

        // reset during JUMP
        step(1, 0, 0);
        step(1, 1, 0);
        cyc(1'b0, 1, cur_vec, cur_pc, 1, 0, 0, 0, 3'd4, 8'h00);
        cyc(1'b0, 0, cur_vec, cur_pc, 0, 0, 0, 0, 3'd0, 8'h00);
        rd_chk("post_reset_tcnt", 3'd4, 1'b0, 8'h00);
        rd_chk("post_reset_epc1", 3'd1, 1'b0, 8'h00);

        // saturation over 256 entries
        for (int n = 0; n < 256; n++) begin
            step(1, 1, 0);
            step(1, 1, 0);
            step(0, 0, 0);
            step(0, 0, 1);
            step(0, 0, 0);
        end
        rd_chk("tcnt_saturated", 3'd4, 1'b0, 8'hFF);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rv = $urandom;
            rp = $urandom;
            rd = $urandom;
            cyc($urandom_range(0, 199) != 0, $urandom_range(0, 2) != 0, rv[23:0], rp[23:0],
                $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
                rd[2:0], rd[15:8]);
        end
        step(0, 0, 0);

        @(posedge clk);
        #2;
        chk("status_queue_drained", 32'(st_q.size()), 32'h0);
        chk("redirect_queue_drained", 32'(ev_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
